// File: rtl/instr_fetch_unit.sv
// Instruction fetch controller: owns the PC, reads instruction RAM, holds the word in IR
// and offers it to the decoder over valid/ready. Supports branch redirect and halt.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 24,
  parameter int unsigned          DATA_W   = 24,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              iram_read,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              halt
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALTED} state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_read, r_valid;
  logic [DATA_W-1:0]  r_ir;
  logic [ADDR_W-1:0]  r_pc_out;
  logic               w_cap, w_xfer, w_last;

  assign w_xfer = r_valid & ir_ready;
  assign w_last = (r_cnt == CNT_W'(MEM_LAT - 1));

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    case (r_state)
      S_IDLE:   w_next = halt ? S_HALTED : S_FETCH;
      S_FETCH: begin
        if (halt) w_next = S_HALTED;
        else if (w_last) begin
          w_cap  = 1'b1;
          w_next = S_HOLD;
        end
      end
      S_HOLD:   if (w_xfer) w_next = halt ? S_HALTED : S_FETCH;
      S_HALTED: if (!halt) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
    // A redirect overrides everything, including a completing read
    if (branch_en) begin
      w_next = halt ? S_HALTED : S_FETCH;
      w_cap  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_read   <= 1'b0;
      r_valid  <= 1'b0;
      r_ir     <= '0;
      r_pc_out <= '0;
    end else begin
      r_state <= w_next;
      r_read  <= (w_next == S_FETCH);

      if (branch_en)  r_pc <= branch_addr;
      else if (w_cap) r_pc <= r_pc + 1'b1;

      if (r_state == S_FETCH && w_next == S_FETCH && !branch_en) r_cnt <= r_cnt + 1'b1;
      else                                                      r_cnt <= '0;

      if (branch_en)   r_valid <= 1'b0;
      else if (w_cap)  r_valid <= 1'b1;
      else if (w_xfer) r_valid <= 1'b0;

      if (w_cap) begin
        r_ir     <= iram_data;
        r_pc_out <= r_pc;
      end
    end
  end

  assign iram_read = r_read;
  assign iram_addr = r_pc;
  assign ir_out    = r_ir;
  assign ir_valid  = r_valid;
  assign pc_out    = r_pc_out;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (MEM_LAT=1): sequential fetch, stall, branch,
// branch+transfer, PC wrap, halt in FETCH/HOLD/HALTED, and async reset mid-HOLD.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        iram_read;
  logic [23:0] iram_addr, iram_data, ir_out, pc_out, branch_addr;
  logic        ir_valid, ir_ready, branch_en, halt;
  int          n_chk = 0, n_err = 0;

  instr_fetch_unit #(.ADDR_W(24), .DATA_W(24), .RESET_PC(24'h0), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .iram_read(iram_read), .iram_addr(iram_addr),
    .iram_data(iram_data), .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc_out(pc_out), .branch_en(branch_en), .branch_addr(branch_addr), .halt(halt)
  );

  always #5 clk = ~clk;

  // Combinational instruction RAM with a few marker words
  always_comb begin
    case (iram_addr)
      24'h000000: iram_data = 24'hA0A0A0;
      24'h000001: iram_data = 24'hB1B1B1;
      24'h000002: iram_data = 24'hC2C2C2;
      24'h000003: iram_data = 24'hD3D3D3;
      24'h000100: iram_data = 24'h111111;
      24'h000101: iram_data = 24'h222222;
      24'h000200: iram_data = 24'h333333;
      24'hFFFFFF: iram_data = 24'hEEEEEE;
      default:    iram_data = 24'h5A5A5A;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b1; branch_en = 1'b0; branch_addr = '0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ir_valid), 32'h0);
    chk("rst_read",  32'(iram_read), 32'h0);
    chk("rst_addr",  32'(iram_addr), 32'h0);
    chk("rst_ir",    32'(ir_out), 32'h0);
    chk("rst_pcout", 32'(pc_out), 32'h0);
    rst = 1'b0;
    chk("idle_read", 32'(iram_read), 32'h0);

    // 1: sequential fetch A,B
    tick();
    chk("f0_read", 32'(iram_read), 32'h1);
    chk("f0_addr", 32'(iram_addr), 32'h0);
    tick();
    chk("A_ir",    32'(ir_out), 32'hA0A0A0);
    chk("A_valid", 32'(ir_valid), 32'h1);
    chk("A_pc",    32'(pc_out), 32'h0);
    chk("A_read",  32'(iram_read), 32'h0);
    tick();
    chk("f1_addr", 32'(iram_addr), 32'h1);
    tick();
    chk("B_ir", 32'(ir_out), 32'hB1B1B1);
    chk("B_pc", 32'(pc_out), 32'h1);

    // 2: decoder stalls on B
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ir",    32'(ir_out), 32'hB1B1B1);
      chk("stall_valid", 32'(ir_valid), 32'h1);
      chk("stall_read",  32'(iram_read), 32'h0);
      chk("stall_pc",    32'(iram_addr), 32'h2);
    end
    ir_ready = 1'b1;
    tick();
    chk("f2_addr", 32'(iram_addr), 32'h2);
    tick();
    chk("C_ir", 32'(ir_out), 32'hC2C2C2);
    chk("C_pc", 32'(pc_out), 32'h2);
    tick();
    chk("f3_addr", 32'(iram_addr), 32'h3);

    // 3: branch during FETCH of addr 3
    branch_en = 1'b1; branch_addr = 24'h000100;
    tick();
    branch_en = 1'b0;
    chk("br_valid", 32'(ir_valid), 32'h0);
    chk("br_addr",  32'(iram_addr), 32'h100);
    chk("br_read",  32'(iram_read), 32'h1);
    tick();
    chk("br_ir", 32'(ir_out), 32'h111111);
    chk("br_pc", 32'(pc_out), 32'h100);

    // 4: branch coincident with transfer
    branch_en = 1'b1; branch_addr = 24'h000200;
    tick();
    branch_en = 1'b0;
    chk("bx_valid", 32'(ir_valid), 32'h0);
    chk("bx_addr",  32'(iram_addr), 32'h200);
    tick();
    chk("bx_ir", 32'(ir_out), 32'h333333);

    // 5: PC wrap
    ir_ready = 1'b0; branch_en = 1'b1; branch_addr = 24'hFFFFFF;
    tick();
    branch_en = 1'b0; ir_ready = 1'b1;
    chk("wr_addr", 32'(iram_addr), 32'hFFFFFF);
    tick();
    chk("wr_ir",   32'(ir_out), 32'hEEEEEE);
    chk("wr_pc",   32'(pc_out), 32'hFFFFFF);
    chk("wr_next", 32'(iram_addr), 32'h0);
    tick();
    chk("wr_read", 32'(iram_read), 32'h1);

    // 6: halt during FETCH of addr 0
    halt = 1'b1;
    tick();
    chk("hf_read",  32'(iram_read), 32'h0);
    chk("hf_valid", 32'(ir_valid), 32'h0);
    chk("hf_pc",    32'(iram_addr), 32'h0);
    branch_en = 1'b1; branch_addr = 24'h000100;
    tick();
    branch_en = 1'b0;
    chk("hb_read", 32'(iram_read), 32'h0);
    chk("hb_pc",   32'(iram_addr), 32'h100);
    halt = 1'b0;
    tick();
    chk("hr_read", 32'(iram_read), 32'h1);
    chk("hr_addr", 32'(iram_addr), 32'h100);
    ir_ready = 1'b0;
    tick();
    chk("hh_ir", 32'(ir_out), 32'h111111);
    halt = 1'b1;
    tick();
    chk("hh_valid", 32'(ir_valid), 32'h1);
    chk("hh_ir2",   32'(ir_out), 32'h111111);
    ir_ready = 1'b1;
    tick();
    chk("hh_done_valid", 32'(ir_valid), 32'h0);
    chk("hh_done_read",  32'(iram_read), 32'h0);
    chk("hh_done_pc",    32'(iram_addr), 32'h101);
    halt = 1'b0; ir_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_ir", 32'(ir_out), 32'h222222);

    // async reset mid-HOLD
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(ir_valid), 32'h0);
    chk("ar_pc",    32'(iram_addr), 32'h0);
    chk("ar_ir",    32'(ir_out), 32'h0);
    chk("ar_pcout", 32'(pc_out), 32'h0);
    ir_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("ar_idle", 32'(iram_read), 32'h0);
    tick();
    chk("ar_fetch", 32'(iram_read), 32'h1);
    tick();
    chk("ar_A", 32'(ir_out), 32'hA0A0A0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
